// File: rtl/hand_accumulator.sv
// hand_accumulator
//   Keeps the running score of one baccarat hand (player or banker). Cards
//   arrive one per valid/ready handshake; the block tracks the score modulo
//   MODULUS, the number of legal cards taken, the natural flag and the point
//   value of the last card. Two instances sit beside the dealer FSM.
//
// Ports
//   slow_clock  in   sole clock, rising edge
//   resetb      in   asynchronous active-low reset
//   clear       in   synchronous start-of-hand clear, wins over card_valid
//   card_valid  in   card offered this cycle
//   card        in   [3:0] card code: 1=A, 2..10 pip, 11..13 J/Q/K; others illegal
//   card_ready  out  block can take a card this cycle
//   total       out  [TOT_W-1:0] hand score modulo MODULUS
//   card_count  out  [CNT_W-1:0] legal cards accepted
//   hand_full   out  card_count == MAX_CARDS
//   natural     out  second card brought total to NATURAL_MIN or more
//   last_value  out  [3:0] point value of the last accepted card
//   card_err    out  one-cycle pulse after an illegal code is consumed
`timescale 1ns/1ps
module hand_accumulator #(
    parameter int MAX_CARDS   = 3,
    parameter int MODULUS     = 10,
    parameter int NATURAL_MIN = 8,
    localparam int CNT_W      = $clog2(MAX_CARDS + 1),
    localparam int TOT_W      = 4
) (
    input  logic             slow_clock,
    input  logic             resetb,
    input  logic             clear,
    input  logic             card_valid,
    input  logic [3:0]       card,
    output logic             card_ready,
    output logic [TOT_W-1:0] total,
    output logic [CNT_W-1:0] card_count,
    output logic             hand_full,
    output logic             natural,
    output logic [3:0]       last_value,
    output logic             card_err
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CARDS);
    localparam logic [4:0]       MOD_5 = 5'(MODULUS);
    localparam logic [TOT_W-1:0] NAT_T = TOT_W'(NATURAL_MIN);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        DEALING = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t state;

    // Codes 10..13 score zero; codes 0 and 14..15 never reach the score.
    function automatic logic [3:0] point_value(input logic [3:0] code);
        return (code >= 4'd1 && code <= 4'd9) ? code : 4'd0;
    endfunction

    function automatic logic is_legal(input logic [3:0] code);
        return (code >= 4'd1) && (code <= 4'd13);
    endfunction

    // Inputs never exceed MODULUS-1 + 9, so one conditional subtract wraps.
    function automatic logic [TOT_W-1:0] mod_add(input logic [TOT_W-1:0] a,
                                                 input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= MOD_5) ? TOT_W'(sum - MOD_5) : TOT_W'(sum);
    endfunction

    logic             accept;
    logic             legal;
    logic [3:0]       value;
    logic [TOT_W-1:0] tot_next;
    logic [CNT_W-1:0] cnt_next;

    assign hand_full  = (card_count == MAX_C);
    assign card_ready = !hand_full && !clear;
    assign accept     = card_valid && card_ready;
    assign legal      = is_legal(card);
    assign value      = point_value(card);
    assign tot_next   = mod_add(total, value);
    assign cnt_next   = card_count + CNT_W'(1);

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state      <= EMPTY;
            total      <= '0;
            card_count <= '0;
            natural    <= 1'b0;
            last_value <= 4'd0;
            card_err   <= 1'b0;
        end else if (clear) begin
            state      <= EMPTY;
            total      <= '0;
            card_count <= '0;
            natural    <= 1'b0;
            last_value <= 4'd0;
            card_err   <= 1'b0;
        end else begin
            card_err <= 1'b0;
            case (state)
                EMPTY, DEALING: begin
                    if (accept) begin
                        if (!legal) begin
                            card_err <= 1'b1;
                        end else begin
                            total      <= tot_next;
                            card_count <= cnt_next;
                            last_value <= value;
                            // Only the second legal card can raise natural.
                            if (card_count == CNT_W'(1) && tot_next >= NAT_T)
                                natural <= 1'b1;
                            state <= (cnt_next == MAX_C) ? FULL : DEALING;
                        end
                    end
                end
                FULL: state <= FULL;
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_hand_accumulator.sv
// tb_hand_accumulator
//   Table-driven bench for hand_accumulator. Instance a uses the default
//   parameters, instance b uses MAX_CARDS=5, MODULUS=12, NATURAL_MIN=10.
//   Each vector is pushed to a scoreboard queue when driven and popped and
//   compared one edge later. The asynchronous reset is exercised by hand.
`timescale 1ns/1ps
module tb_hand_accumulator;

    logic slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    logic resetb;

    logic       clr_a, vld_a, rdy_a, full_a, nat_a, err_a;
    logic [3:0] card_a, tot_a, last_a;
    logic [1:0] cnt_a;

    logic       clr_b, vld_b, rdy_b, full_b, nat_b, err_b;
    logic [3:0] card_b, tot_b, last_b;
    logic [2:0] cnt_b;

    hand_accumulator u_a (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clear      (clr_a),
        .card_valid (vld_a),
        .card       (card_a),
        .card_ready (rdy_a),
        .total      (tot_a),
        .card_count (cnt_a),
        .hand_full  (full_a),
        .natural    (nat_a),
        .last_value (last_a),
        .card_err   (err_a)
    );

    hand_accumulator #(.MAX_CARDS(5), .MODULUS(12), .NATURAL_MIN(10)) u_b (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .clear      (clr_b),
        .card_valid (vld_b),
        .card       (card_b),
        .card_ready (rdy_b),
        .total      (tot_b),
        .card_count (cnt_b),
        .hand_full  (full_b),
        .natural    (nat_b),
        .last_value (last_b),
        .card_err   (err_b)
    );

    typedef struct {
        bit         dut;
        bit         clr;
        bit         vld;
        logic [3:0] card;
        logic [3:0] tot;
        logic [3:0] cnt;
        bit         full;
        bit         nat;
        logic [3:0] last;
        bit         err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(bit dut, bit clr, bit vld, int card, int tot,
                                int cnt, bit full, bit nat, int last, bit err);
        vec_t v;
        v.dut = dut; v.clr = clr; v.vld = vld; v.card = 4'(card);
        v.tot = 4'(tot); v.cnt = 4'(cnt); v.full = full; v.nat = nat;
        v.last = 4'(last); v.err = err;
        return v;
    endfunction

    task automatic compare(input vec_t e, input string tag);
        if (e.dut == 1'b0) begin
            chk({tag, " total"}, int'(tot_a), int'(e.tot));
            chk({tag, " count"}, int'(cnt_a), int'(e.cnt));
            chk({tag, " full"},  int'(full_a), int'(e.full));
            chk({tag, " ready"}, int'(rdy_a), int'(!e.full));
            chk({tag, " natural"}, int'(nat_a), int'(e.nat));
            chk({tag, " last"},  int'(last_a), int'(e.last));
            chk({tag, " err"},   int'(err_a), int'(e.err));
        end else begin
            chk({tag, " total"}, int'(tot_b), int'(e.tot));
            chk({tag, " count"}, int'(cnt_b), int'(e.cnt));
            chk({tag, " full"},  int'(full_b), int'(e.full));
            chk({tag, " ready"}, int'(rdy_b), int'(!e.full));
            chk({tag, " natural"}, int'(nat_b), int'(e.nat));
            chk({tag, " last"},  int'(last_b), int'(e.last));
            chk({tag, " err"},   int'(err_b), int'(e.err));
        end
    endtask

    // Called at a falling edge: drive, take one rising edge, compare.
    task automatic apply(input vec_t v, input string tag);
        if (v.dut == 1'b0) begin
            clr_a = v.clr; vld_a = v.vld; card_a = v.card;
        end else begin
            clr_b = v.clr; vld_b = v.vld; card_b = v.card;
        end
        sb.push_back(v);
        #1;
        if (v.clr)
            chk({tag, " ready during clear"},
                int'(v.dut ? rdy_b : rdy_a), 0);
        @(posedge slow_clock);
        #1;
        clr_a = 1'b0; vld_a = 1'b0; clr_b = 1'b0; vld_b = 1'b0;
        @(negedge slow_clock);
        compare(sb.pop_front(), tag);
    endtask

    initial begin
        clr_a = 0; vld_a = 0; card_a = 0;
        clr_b = 0; vld_b = 0; card_b = 0;
        resetb = 1'b0;

        // Instance a, defaults: MAX_CARDS=3, MODULUS=10, NATURAL_MIN=8
        vecs.push_back(mk(0,0,1, 7,  7,1,0,0,7,0));
        vecs.push_back(mk(0,0,1, 8,  5,2,0,0,8,0));
        vecs.push_back(mk(0,0,1,13,  5,3,1,0,0,0));
        vecs.push_back(mk(0,0,1, 9,  5,3,1,0,0,0));
        vecs.push_back(mk(0,0,1, 9,  5,3,1,0,0,0));
        vecs.push_back(mk(0,0,1, 9,  5,3,1,0,0,0));
        vecs.push_back(mk(0,0,1, 9,  5,3,1,0,0,0));
        vecs.push_back(mk(0,1,1, 9,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1, 4,  4,1,0,0,4,0));
        vecs.push_back(mk(0,0,1, 5,  9,2,0,1,5,0));
        vecs.push_back(mk(0,0,1, 3,  2,3,1,1,3,0));
        vecs.push_back(mk(0,1,0, 0,  0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1, 0,  0,0,0,0,0,1));
        vecs.push_back(mk(0,0,1,14,  0,0,0,0,0,1));
        vecs.push_back(mk(0,0,1, 6,  6,1,0,0,6,0));
        vecs.push_back(mk(0,0,0, 6,  6,1,0,0,6,0));
        vecs.push_back(mk(0,0,1,15,  6,1,0,0,6,1));
        vecs.push_back(mk(0,0,0, 0,  6,1,0,0,6,0));
        vecs.push_back(mk(0,0,1,10,  6,2,0,0,0,0));
        // Instance b: MAX_CARDS=5, MODULUS=12, NATURAL_MIN=10
        vecs.push_back(mk(1,0,1, 9,  9,1,0,0,9,0));
        vecs.push_back(mk(1,0,1, 9,  6,2,0,0,9,0));
        vecs.push_back(mk(1,0,1, 9,  3,3,0,0,9,0));
        vecs.push_back(mk(1,0,1, 9,  0,4,0,0,9,0));
        vecs.push_back(mk(1,0,1, 9,  9,5,1,0,9,0));
        vecs.push_back(mk(1,0,1, 1,  9,5,1,0,9,0));
        vecs.push_back(mk(1,1,0, 0,  0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1, 5,  5,1,0,0,5,0));
        vecs.push_back(mk(1,0,1, 6, 11,2,0,1,6,0));

        repeat (3) @(posedge slow_clock);
        @(negedge slow_clock);
        resetb = 1'b1;
        #1;
        compare(mk(0,0,0,0, 0,0,0,0,0,0), "reset a");
        compare(mk(1,0,0,0, 0,0,0,0,0,0), "reset b");

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Start a fresh hand on a, deal 9, 9, then reset between edges.
        apply(mk(0,1,0,0, 0,0,0,0,0,0), "async clear");
        apply(mk(0,0,1,9, 9,1,0,0,9,0), "async 9a");
        apply(mk(0,0,1,9, 8,2,0,1,9,0), "async 9b");
        #2;
        resetb = 1'b0;
        #1;
        chk("async total", int'(tot_a), 0);
        chk("async count", int'(cnt_a), 0);
        chk("async natural", int'(nat_a), 0);
        chk("async last", int'(last_a), 0);
        vld_a = 1'b1; card_a = 4'd5;
        @(posedge slow_clock);
        #1;
        chk("held reset total", int'(tot_a), 0);
        chk("held reset count", int'(cnt_a), 0);
        @(negedge slow_clock);
        vld_a = 1'b0;
        resetb = 1'b1;
        #1;
        compare(mk(0,0,0,0, 0,0,0,0,0,0), "post reset");
        @(negedge slow_clock);
        apply(mk(0,0,1,2, 2,1,0,0,2,0), "after reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
